// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl
//   Drives the 8-bit duty levels of the R/G/B PWM generators. A target colour
//   and step rate are taken over a valid/ready handshake. Each channel then
//   moves one LSB per step toward its target. A one-cycle done pulse marks
//   completion.
//
// Ports
//   clk              system clock, all state on the rising edge
//   reset_n          asynchronous active-low reset
//   tgt_valid/ready  target handshake (ready is combinational from state)
//   tgt_r/g/b        8-bit target levels
//   rate             step period minus one, in clk cycles (RATE_W bits)
//   level_r/g/b      8-bit duty levels to the PWM instances
//   busy             high while fading
//   done             registered one-cycle completion pulse
//
// Build option
//   RGB_FADE_RETARGET_EN  when defined, a new target may be accepted during a
//                         fade. The fade then continues from the current
//                         levels, and the interrupted fade raises no done.
module rgb_fade_ctrl #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [7:0]        tgt_r,
  input  logic [7:0]        tgt_g,
  input  logic [7:0]        tgt_b,
  input  logic [RATE_W-1:0] rate,
  output logic [7:0]        level_r,
  output logic [7:0]        level_g,
  output logic [7:0]        level_b,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, FADE} state_t;

  state_t            state, state_next;
  logic              done_next;
  logic [7:0]        cap_r, cap_g, cap_b;
  logic [RATE_W-1:0] cap_rate;
  logic [RATE_W-1:0] presc;
  logic              accept;
  logic              at_target;
  logic              step_en;

  // Move one LSB toward the target. This never passes the target, so the
  // level cannot wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

`ifdef RGB_FADE_RETARGET_EN
  assign tgt_ready = reset_n;
`else
  assign tgt_ready = (state == IDLE) && reset_n;
`endif

  assign busy      = (state == FADE);
  assign accept    = tgt_valid && tgt_ready;
  assign at_target = (level_r == cap_r) && (level_g == cap_g) && (level_b == cap_b);
  // An accept on the same edge takes precedence over a step. Without
  // retargeting, an accept can only occur in IDLE.
  assign step_en   = (state == FADE) && !at_target && !accept && (presc == cap_rate);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = FADE;
      end
      FADE: begin
`ifdef RGB_FADE_RETARGET_EN
        // A retarget on the completion edge keeps the block fading.
        if (accept) begin
          state_next = FADE;
        end else if (at_target) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
`else
        if (at_target) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_r    <= 8'd0;
      cap_g    <= 8'd0;
      cap_b    <= 8'd0;
      cap_rate <= '0;
      presc    <= '0;
      level_r  <= 8'd0;
      level_g  <= 8'd0;
      level_b  <= 8'd0;
    end else begin
      if (accept) begin
        cap_r    <= tgt_r;
        cap_g    <= tgt_g;
        cap_b    <= tgt_b;
        cap_rate <= rate;
        presc    <= '0;
      end else if (step_en) begin
        presc <= '0;
      end else if ((state == FADE) && !at_target) begin
        presc <= presc + RATE_W'(1);
      end

      if (step_en) begin
        level_r <= step_toward(level_r, cap_r);
        level_g <= step_toward(level_g, cap_g);
        level_b <= step_toward(level_b, cap_b);
      end
    end
  end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Directed bench for rgb_fade_ctrl. Inputs are driven and outputs sampled 1 ns
// after each rising edge. "Edge e" counts rising edges after the accept edge.
module tb_rgb_fade_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [7:0] tgt_r = 8'd0, tgt_g = 8'd0, tgt_b = 8'd0;
  logic [7:0] rate = 8'd0;
  logic [7:0] level_r, level_g, level_b;
  logic       busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgb_fade_ctrl #(.RATE_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b), .rate(rate),
    .level_r(level_r), .level_g(level_g), .level_b(level_b),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a target for one edge (the accept edge). Return 1 ns after it.
  task automatic offer(input int r, input int g, input int b, input int rt);
    tgt_r = 8'(r); tgt_g = 8'(g); tgt_b = 8'(b); rate = 8'(rt);
    tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("wait_done", seen, 1'b1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_level_r", level_r, 0);
    chk("rst_level_g", level_g, 0);
    chk("rst_level_b", level_b, 0);
    chk("rst_ready",   tgt_ready, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_done",    done, 0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("idle_ready", tgt_ready, 1);

    // (4,2,0) at rate 1: steps on even edges, done after edge 9
    offer(4, 2, 0, 1);
    chk("t1_busy0",  busy, 1);
    chk("t1_ready0", tgt_ready, 0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("t1_r", level_r, imin(4, e / 2));
      chk("t1_g", level_g, imin(2, e / 2));
      chk("t1_b", level_b, 0);
      chk("t1_done",  done, (e == 9) ? 1 : 0);
      chk("t1_busy",  busy, (e < 9) ? 1 : 0);
      chk("t1_ready", tgt_ready, (e >= 9) ? 1 : 0);
    end

    // Target equal to current levels: done one edge after accept
    offer(4, 2, 0, 5);
    chk("t2_busy", busy, 1);
    chk("t2_done0", done, 0);
    tick();
    chk("t2_done", done, 1);
    chk("t2_busy_off", busy, 0);
    chk("t2_lvl", {level_r, level_g, level_b}, {8'd4, 8'd2, 8'd0});
    tick();
    chk("t2_done_off", done, 0);

    // Ramp to full scale, then 255 consecutive decrements at rate 0
    offer(255, 255, 255, 0);
    wait_done(300);
    chk("t3_full", {level_r, level_g, level_b}, {8'd255, 8'd255, 8'd255});
    tick();
    offer(0, 0, 0, 0);
    for (int k = 1; k <= 257; k++) begin
      tick();
      if (k <= 255) begin
        chk("t3_dec_r", level_r, 255 - k);
        chk("t3_dec_b", level_b, 255 - k);
      end else begin
        chk("t3_zero", {level_r, level_g, level_b}, 24'd0);
      end
      chk("t3_done", done, (k == 256) ? 1 : 0);
    end

    // Asynchronous reset mid-fade
    offer(100, 0, 0, 0);
    tick(); tick(); tick();
    chk("t4_pre", level_r, 3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t4_lvl_r", level_r, 0);
    chk("t4_busy",  busy, 0);
    chk("t4_ready", tgt_ready, 0);
    chk("t4_done",  done, 0);
    tick();
    chk("t4_done_hold", done, 0);
    reset_n = 1'b1;
    #1;
    chk("t4_ready_back", tgt_ready, 1);

    // Rate 3, r 0 -> 2: steps at edges 4 and 8, done after edge 9
    offer(2, 0, 0, 3);
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("t6_r", level_r, (e >= 8) ? 2 : ((e >= 4) ? 1 : 0));
      chk("t6_done", done, (e == 9) ? 1 : 0);
    end

    // New data offered mid-fade (at edge 3)
    offer(5, 5, 5, 0);
    for (int e = 1; e <= 12; e++) begin
      int er, eg;
      logic ed;
      if (e == 3) begin
`ifndef RGB_FADE_RETARGET_EN
        chk("t5_ready_fade", tgt_ready, 0);
`endif
        tgt_r = 8'd9; tgt_g = 8'd9; tgt_b = 8'd9; rate = 8'd0;
        tgt_valid = 1'b1;
      end
      tick();
      tgt_valid = 1'b0;
`ifdef RGB_FADE_RETARGET_EN
      if (e <= 2) begin
        er = 2 + e; eg = e;
      end else if (e == 3) begin
        er = 4; eg = 2;
      end else begin
        er = imin(9, 4 + (e - 3)); eg = imin(9, 2 + (e - 3));
      end
      ed = (e == 11);
`else
      er = imin(5, 2 + e); eg = imin(5, e);
      ed = (e == 6);
`endif
      chk("t5_r", level_r, er);
      chk("t5_g", level_g, eg);
      chk("t5_b", level_b, eg);
      chk("t5_done", done, ed);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
